// File: rtl/core_accu_pkg.sv
// Shared types and width defaults for the accumulation stage.
// The width macros normally come from the core-wide defines, so quant and accu widths agree.
`ifndef IDATA_WIDTH
`define IDATA_WIDTH 16
`endif
`ifndef ODATA_WIDTH
`define ODATA_WIDTH 24
`endif
`ifndef CDATA_ACCU_NUM_WIDTH
`define CDATA_ACCU_NUM_WIDTH 10
`endif

package core_accu_pkg;

  localparam int unsigned IdataWidthDef = `IDATA_WIDTH;
  localparam int unsigned OdataWidthDef = `ODATA_WIDTH;
  localparam int unsigned AccuNumWidthDef = `CDATA_ACCU_NUM_WIDTH;

  typedef enum logic [0:0] {
    StIdle,
    StAccum
  } accu_state_e;

endpackage

// File: rtl/core_accu_if.sv
// Data-in / result-out bundle between the MAC array, the accumulator and the quant stage.
interface core_accu_if #(
  parameter int unsigned IDATA_WIDTH = 16,
  parameter int unsigned ODATA_WIDTH = 24
);
  logic [IDATA_WIDTH-1:0] idata;
  logic                   idata_valid;
  logic [ODATA_WIDTH-1:0] odata;
  logic                   odata_valid;
  logic                   odata_sat;

  modport master (
    output idata,
    output idata_valid,
    input  odata,
    input  odata_valid,
    input  odata_sat
  );

  modport slave (
    input  idata,
    input  idata_valid,
    output odata,
    output odata_valid,
    output odata_sat
  );
endinterface

// File: rtl/core_accu_sat_add.sv
// Combinational signed saturating adder: WIDTH + WIDTH -> WIDTH with an overflow flag.
module core_accu_sat_add #(
  parameter int unsigned WIDTH = 24
) (
  input  logic signed [WIDTH-1:0] a_i,
  input  logic signed [WIDTH-1:0] b_i,
  output logic signed [WIDTH-1:0] sum_o,
  output logic                    ovf_o
);

  logic [WIDTH:0] full;

  always_comb begin
    full  = {a_i[WIDTH-1], a_i} + {b_i[WIDTH-1], b_i};
    // Overflow when the extra sign bit disagrees with the result sign bit.
    ovf_o = full[WIDTH] ^ full[WIDTH-1];
    if (!ovf_o) begin
      sum_o = full[WIDTH-1:0];
    end else if (full[WIDTH]) begin
      sum_o = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      sum_o = {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/core_accu.sv
// Accumulates windows of signed partial products with saturation ahead of the quantizer.
// One registered result per window; back-to-back windows need no idle cycle.
module core_accu
  import core_accu_pkg::*;
#(
  parameter int unsigned IDATA_WIDTH          = IdataWidthDef,
  parameter int unsigned ODATA_WIDTH          = OdataWidthDef,
  parameter int unsigned CDATA_ACCU_NUM_WIDTH = AccuNumWidthDef
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [CDATA_ACCU_NUM_WIDTH-1:0] cfg_acc_num,
  input  logic                            acc_clear,
  core_accu_if.slave                      bus
);

  localparam int unsigned CW = CDATA_ACCU_NUM_WIDTH;
  localparam int unsigned OW = ODATA_WIDTH;

  accu_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CW-1:0]        len_q, len_d;
  logic signed [OW-1:0] acc_q, acc_d;
  logic                 sticky_q, sticky_d;
  logic [OW-1:0]        odata_q, odata_d;
  logic                 ovalid_q, ovalid_d;
  logic                 osat_q, osat_d;

  logic signed [OW-1:0] idata_sext;
  logic signed [OW-1:0] add_sum;
  logic                 add_ovf;

  logic                 first;
  logic [CW-1:0]        win_len;
  logic [CW-1:0]        cnt_inc;
  logic signed [OW-1:0] step_sum;
  logic                 step_sat;

  assign idata_sext = {{(OW-IDATA_WIDTH){bus.idata[IDATA_WIDTH-1]}}, bus.idata};

  core_accu_sat_add #(
    .WIDTH (OW)
  ) u_sat_add (
    .a_i   (acc_q),
    .b_i   (idata_sext),
    .sum_o (add_sum),
    .ovf_o (add_ovf)
  );

  // A new window latches its length from cfg; later inputs use the latched value.
  always_comb begin
    first    = (state_q == StIdle);
    win_len  = len_q;
    cnt_inc  = cnt_q + CW'(1);
    step_sum = add_sum;
    step_sat = sticky_q | add_ovf;
    if (first) begin
      win_len  = (cfg_acc_num == '0) ? CW'(1) : cfg_acc_num;
      cnt_inc  = CW'(1);
      step_sum = idata_sext;
      step_sat = 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    acc_d    = acc_q;
    sticky_d = sticky_q;
    odata_d  = odata_q;
    ovalid_d = 1'b0;
    osat_d   = osat_q;

    if (acc_clear) begin
      state_d  = StIdle;
      cnt_d    = '0;
      acc_d    = '0;
      sticky_d = 1'b0;
    end else if (bus.idata_valid) begin
      if (cnt_inc == win_len) begin
        state_d  = StIdle;
        cnt_d    = '0;
        acc_d    = '0;
        sticky_d = 1'b0;
        odata_d  = step_sum;
        ovalid_d = 1'b1;
        osat_d   = step_sat;
      end else begin
        state_d  = StAccum;
        cnt_d    = cnt_inc;
        len_d    = win_len;
        acc_d    = step_sum;
        sticky_d = step_sat;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      len_q    <= '0;
      acc_q    <= '0;
      sticky_q <= 1'b0;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
      osat_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      acc_q    <= acc_d;
      sticky_q <= sticky_d;
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
      osat_q   <= osat_d;
    end
  end

  assign bus.odata       = odata_q;
  assign bus.odata_valid = ovalid_q;
  assign bus.odata_sat   = osat_q;

endmodule

// File: tb/tb_core_accu.sv
// Bench for core_accu: directed windows plus random traffic against a plain-arithmetic model.
module tb_core_accu;

  localparam int unsigned IW = 16;
  localparam int unsigned OW = 24;
  localparam int unsigned CW = 10;
  localparam longint SMAX = (longint'(1) <<< (OW - 1)) - 1;
  localparam longint SMIN = -(longint'(1) <<< (OW - 1));

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [CW-1:0] cfg_acc_num = '0;
  logic          acc_clear = 1'b0;

  core_accu_if #(.IDATA_WIDTH(IW), .ODATA_WIDTH(OW)) bus ();

  core_accu #(
    .IDATA_WIDTH          (IW),
    .ODATA_WIDTH          (OW),
    .CDATA_ACCU_NUM_WIDTH (CW)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .cfg_acc_num (cfg_acc_num),
    .acc_clear   (acc_clear),
    .bus         (bus.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state: the open window as a list of plain integers.
  bit     m_open = 0;
  longint m_len = 0;
  longint m_cnt = 0;
  longint m_sum = 0;
  bit     m_sticky = 0;
  longint exp_odata = 0;
  bit     exp_valid = 0;
  bit     exp_sat = 0;

  task automatic check_val(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_open = 0; m_len = 0; m_cnt = 0; m_sum = 0; m_sticky = 0;
    exp_odata = 0; exp_valid = 0; exp_sat = 0;
  endtask

  task automatic model_step(input bit v, input longint d, input bit clr, input longint cfg);
    exp_valid = 0;
    if (clr) begin
      m_open = 0; m_cnt = 0; m_sum = 0; m_sticky = 0;
    end else if (v) begin
      if (!m_open) begin
        m_open = 1;
        m_len = (cfg == 0) ? 1 : cfg;
        m_cnt = 1;
        m_sum = d;
        m_sticky = 0;
      end else begin
        m_sum = m_sum + d;
        if (m_sum > SMAX) begin m_sum = SMAX; m_sticky = 1; end
        if (m_sum < SMIN) begin m_sum = SMIN; m_sticky = 1; end
        m_cnt++;
      end
      if (m_cnt == m_len) begin
        exp_valid = 1;
        exp_odata = m_sum;
        exp_sat = m_sticky;
        m_open = 0; m_cnt = 0; m_sum = 0; m_sticky = 0;
      end
    end
  endtask

  task automatic compare(input string tag);
    check_val({tag, ".valid"}, longint'(bus.odata_valid), longint'(exp_valid));
    check_val({tag, ".odata"}, longint'($signed(bus.odata)), exp_odata);
    if (exp_valid) check_val({tag, ".sat"}, longint'(bus.odata_sat), longint'(exp_sat));
  endtask

  task automatic drive(input string tag, input bit v, input longint d, input bit clr);
    bus.idata_valid = v;
    bus.idata = IW'(d);
    acc_clear = clr;
    @(posedge clk);
    #1;
    model_step(v, d, clr, longint'(cfg_acc_num));
    compare(tag);
    bus.idata_valid = 1'b0;
    acc_clear = 1'b0;
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) drive(tag, 0, 0, 0);
  endtask

  initial begin
    longint d;
    bus.idata = '0;
    bus.idata_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare("reset");
    check_val("reset.sat", longint'(bus.odata_sat), 0);
    @(negedge clk);
    rstn = 1'b1;
    idle("post_reset", 2);

    // 1+2+3+4 over a window of four.
    cfg_acc_num = 4;
    for (int i = 1; i <= 4; i++) drive("sum4", 1, i, 0);
    idle("sum4", 2);

    // Three back-to-back windows of three -5s.
    cfg_acc_num = 3;
    for (int i = 0; i < 9; i++) drive("b2b", 1, -5, 0);
    idle("b2b", 1);

    // cfg 0 behaves as passthrough.
    cfg_acc_num = 0;
    drive("n0", 1, 7, 0);
    drive("n0", 1, -8, 0);
    idle("n0", 1);

    // Positive saturation, then a clean short window.
    cfg_acc_num = 300;
    for (int i = 0; i < 300; i++) drive("psat", 1, 32767, 0);
    cfg_acc_num = 2;
    drive("after_sat", 1, 1, 0);
    drive("after_sat", 1, 1, 0);
    idle("after_sat", 1);

    // Negative saturation.
    cfg_acc_num = 300;
    for (int i = 0; i < 300; i++) drive("nsat", 1, -32768, 0);
    idle("nsat", 1);

    // Gap inside window, then abort, then a full window.
    cfg_acc_num = 4;
    drive("clr", 1, 1, 0);
    drive("clr", 1, 1, 0);
    idle("clr", 5);
    drive("clr", 0, 0, 1);
    for (int i = 0; i < 4; i++) drive("clr", 1, 2, 0);
    idle("clr", 1);

    // Clear in the same cycle as a valid input drops it; pending pulse still fires.
    cfg_acc_num = 2;
    drive("clr_same", 1, 9, 0);
    drive("clr_same", 1, 9, 0);
    drive("clr_same", 1, 100, 1);
    drive("clr_same", 1, 5, 0);
    drive("clr_same", 1, 6, 0);
    idle("clr_same", 1);

    // Asynchronous reset after two of four inputs.
    cfg_acc_num = 4;
    drive("arst", 1, 3, 0);
    drive("arst", 1, 3, 0);
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    compare("arst_low");
    check_val("arst_low.sat", longint'(bus.odata_sat), 0);
    #1;
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) drive("arst_after", 1, 3, 0);
    idle("arst_after", 1);

    // Random traffic with mid-window cfg changes and occasional aborts.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 31) == 0) cfg_acc_num = CW'($urandom_range(0, 12));
      case ($urandom_range(0, 3))
        0:       d = 32767;
        1:       d = -32768;
        default: d = longint'($signed(16'($urandom)));
      endcase
      drive("rand", ($urandom_range(0, 9) < 7), d, ($urandom_range(0, 63) == 0));
    end
    idle("rand_tail", 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
